ex_cond_unit: RTL and testbench

EX_COND_UNIT -- requirements
Module: ex_cond_unit

---
 rtl/ex_cond_unit_pkg.sv | 41 ++++
 rtl/ex_cond_unit_cond_check.sv | 44 ++++
 rtl/ex_cond_unit.sv | 72 +++++++
 tb/tb_ex_cond_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_cond_unit_pkg.sv
// Shared control definitions for the execute stage: ARM condition codes,
// NZCV flag bit positions and the EX/MEM pipeline register layout.
package ex_cond_unit_pkg;

    // ARM condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the 4-bit NZCV vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic        valid;
        logic        reg_write_enable;
        logic        mem_write_enable;
        logic        mem_to_reg_select;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [3:0]  rd;
    } ex_mem_t;

    localparam ex_mem_t EX_MEM_RESET = '0;

endpackage

// File: rtl/ex_cond_unit_cond_check.sv
// Purely combinational ARM condition decoder: evaluates a 4-bit condition
// field against an NZCV flag vector.
module cond_check
    import ex_cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_cond_unit.sv
// Execute-stage conditional-execution unit: owns the architectural NZCV
// register and the EX/MEM pipeline register, squashing failed/flushed ops.
module ex_cond_unit
    import ex_cond_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [3:0]  cond_in,
    input  logic        status_bits_in,
    input  logic        reg_write_enable_in,
    input  logic        mem_write_enable_in,
    input  logic        mem_to_reg_select_in,
    input  logic [3:0]  alu_flags_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [3:0]  rd_in,
    output logic        cond_pass,
    output logic [3:0]  flags_out,
    output logic        valid_out,
    output logic        reg_write_enable_out,
    output logic        mem_write_enable_out,
    output logic        mem_to_reg_select_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [3:0]  rd_out
);

    logic [3:0] flags_q   = '0;
    ex_mem_t    ex_mem_q  = EX_MEM_RESET;
    logic       exec;

    cond_check u_cond_check (
        .cond  (cond_in),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    // Priority: reset > stall > flush. A stalled stage freezes flags and
    // EX/MEM even when flushed; a flushed or failed op becomes a bubble.
    assign exec = valid_in && cond_pass && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q  <= '0;
            ex_mem_q <= EX_MEM_RESET;
        end else if (!stall) begin
            if (exec && status_bits_in) begin
                flags_q <= alu_flags_in;
            end
            ex_mem_q.valid             <= exec;
            ex_mem_q.reg_write_enable  <= reg_write_enable_in && exec;
            ex_mem_q.mem_write_enable  <= mem_write_enable_in && exec;
            ex_mem_q.mem_to_reg_select <= mem_to_reg_select_in && exec;
            ex_mem_q.alu_result        <= alu_result_in;
            ex_mem_q.store_data        <= store_data_in;
            ex_mem_q.rd                <= rd_in;
        end
    end

    assign flags_out             = flags_q;
    assign valid_out             = ex_mem_q.valid;
    assign reg_write_enable_out  = ex_mem_q.reg_write_enable;
    assign mem_write_enable_out  = ex_mem_q.mem_write_enable;
    assign mem_to_reg_select_out = ex_mem_q.mem_to_reg_select;
    assign alu_result_out        = ex_mem_q.alu_result;
    assign store_data_out        = ex_mem_q.store_data;
    assign rd_out                = ex_mem_q.rd;

endmodule

// File: tb/tb_ex_cond_unit.sv
// Self-checking bench for ex_cond_unit: a reference model pushes expected
// cond_pass and EX/MEM/flag values per cycle; each test pops and compares.
module tb_ex_cond_unit;
    import ex_cond_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in, status_bits_in;
    logic [3:0]  cond_in, alu_flags_in, rd_in;
    logic        reg_write_enable_in, mem_write_enable_in, mem_to_reg_select_in;
    logic [31:0] alu_result_in, store_data_in;
    logic        cond_pass, valid_out;
    logic [3:0]  flags_out, rd_out;
    logic        reg_write_enable_out, mem_write_enable_out, mem_to_reg_select_out;
    logic [31:0] alu_result_out, store_data_out;

    ex_cond_unit dut (
        .clk                   (clk),
        .reset                 (reset),
        .stall                 (stall),
        .flush                 (flush),
        .valid_in              (valid_in),
        .cond_in               (cond_in),
        .status_bits_in        (status_bits_in),
        .reg_write_enable_in   (reg_write_enable_in),
        .mem_write_enable_in   (mem_write_enable_in),
        .mem_to_reg_select_in  (mem_to_reg_select_in),
        .alu_flags_in          (alu_flags_in),
        .alu_result_in         (alu_result_in),
        .store_data_in         (store_data_in),
        .rd_in                 (rd_in),
        .cond_pass             (cond_pass),
        .flags_out             (flags_out),
        .valid_out             (valid_out),
        .reg_write_enable_out  (reg_write_enable_out),
        .mem_write_enable_out  (mem_write_enable_out),
        .mem_to_reg_select_out (mem_to_reg_select_out),
        .alu_result_out        (alu_result_out),
        .store_data_out        (store_data_out),
        .rd_out                (rd_out)
    );

    // clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  c;
        logic        s, rwe, mwe, m2r;
        logic [3:0]  fl;
        logic [31:0] alu, st;
        logic [3:0]  rd;
        logic        stl, fsh, rst;
    } stim_t;

    // scoreboard: {flags, valid, rwe, mwe, m2r, alu, store, rd} = 76 bits
    logic [75:0] exp_q[$];
    logic [0:0]  cp_q[$];
    logic [75:0] e_out;
    logic [0:0]  e_cp;
    logic        last_cp;

    // reference model state
    logic [3:0]  m_flags = '0;
    logic [71:0] m_out   = '0;

    int checks = 0;
    int passed = 0;

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return ~c[0];
        return c[0] ? ~base : base;
    endfunction

    function automatic logic [75:0] observed();
        return {flags_out, valid_out, reg_write_enable_out, mem_write_enable_out,
                mem_to_reg_select_out, alu_result_out, store_data_out, rd_out};
    endfunction

    function automatic stim_t mk(input logic v, input logic [3:0] c, input logic s,
                                 input logic rwe, input logic mwe, input logic m2r,
                                 input logic [3:0] fl, input logic stl, input logic fsh,
                                 input logic rst);
        stim_t t;
        t.v = v; t.c = c; t.s = s; t.rwe = rwe; t.mwe = mwe; t.m2r = m2r; t.fl = fl;
        t.alu = $urandom; t.st = $urandom; t.rd = 4'($urandom_range(0, 15));
        t.stl = stl; t.fsh = fsh; t.rst = rst;
        return t;
    endfunction

    // driver: applies one cycle of stimulus at the falling edge, records the
    // combinational cond_pass, advances to the next falling edge
    task automatic step(input stim_t t);
        logic cp, ex;
        valid_in = t.v; cond_in = t.c; status_bits_in = t.s;
        reg_write_enable_in = t.rwe; mem_write_enable_in = t.mwe;
        mem_to_reg_select_in = t.m2r; alu_flags_in = t.fl;
        alu_result_in = t.alu; store_data_in = t.st; rd_in = t.rd;
        stall = t.stl; flush = t.fsh; reset = t.rst;
        #1;
        last_cp = cond_pass;
        cp = cond_model(t.c, m_flags);
        cp_q.push_back(cp);
        if (t.rst) begin
            m_flags = '0;
            m_out   = '0;
        end else if (!t.stl) begin
            ex = t.v & cp & ~t.fsh;
            if (ex && t.s) m_flags = t.fl;
            m_out = {ex, t.rwe & ex, t.mwe & ex, t.m2r & ex, t.alu, t.st, t.rd};
        end
        exp_q.push_back({m_flags, m_out});
        @(negedge clk);
    endtask

    task automatic test_reset();
        stim_t t[$];
        checks++;
        if (observed() !== 76'd0)
            $display("FAIL init_value got %h exp %h", observed(), 76'd0);
        else passed++;
        t.push_back(mk(1, COND_AL, 1, 1, 1, 1, 4'hf, 0, 0, 1));
        t.push_back(mk(1, COND_AL, 1, 1, 1, 1, 4'hf, 1, 1, 1));
        foreach (t[i]) begin
            step(t[i]);
            e_cp = cp_q.pop_front(); e_out = exp_q.pop_front();
            checks++;
            if (last_cp !== e_cp[0]) $display("FAIL reset[%0d] cond_pass got %b exp %b", i, last_cp, e_cp);
            else passed++;
            checks++;
            if (observed() !== e_out) $display("FAIL reset[%0d] outputs got %h exp %h", i, observed(), e_out);
            else passed++;
        end
    endtask

    task automatic test_flag_eq();
        stim_t t[$];
        t.push_back(mk(1, COND_AL, 1, 0, 0, 0, 4'b0100, 0, 0, 0));
        t.push_back(mk(1, COND_EQ, 0, 1, 0, 0, 4'b0000, 0, 0, 0));
        t.push_back(mk(1, COND_NE, 1, 1, 1, 0, 4'b1111, 0, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            e_cp = cp_q.pop_front(); e_out = exp_q.pop_front();
            checks++;
            if (last_cp !== e_cp[0]) $display("FAIL flag_eq_ne[%0d] cond_pass got %b exp %b", i, last_cp, e_cp);
            else passed++;
            checks++;
            if (observed() !== e_out) $display("FAIL flag_eq_ne[%0d] outputs got %h exp %h", i, observed(), e_out);
            else passed++;
        end
    endtask

    task automatic test_signed();
        stim_t t[$];
        t.push_back(mk(1, COND_AL, 1, 0, 0, 0, 4'b1000, 0, 0, 0));
        t.push_back(mk(1, COND_GE, 0, 1, 0, 0, 4'h0, 0, 0, 0));
        t.push_back(mk(1, COND_LT, 0, 1, 0, 0, 4'h0, 0, 0, 0));
        t.push_back(mk(1, COND_GT, 0, 1, 0, 0, 4'h0, 0, 0, 0));
        t.push_back(mk(1, COND_LE, 0, 1, 0, 1, 4'h0, 0, 0, 0));
        t.push_back(mk(1, COND_AL, 1, 0, 0, 0, 4'b0001, 0, 0, 0));
        t.push_back(mk(1, COND_GE, 0, 1, 1, 0, 4'h0, 0, 0, 0));
        t.push_back(mk(1, COND_AL, 1, 0, 0, 0, 4'b1001, 0, 0, 0));
        t.push_back(mk(1, COND_GE, 0, 1, 1, 0, 4'h0, 0, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            e_cp = cp_q.pop_front(); e_out = exp_q.pop_front();
            checks++;
            if (last_cp !== e_cp[0]) $display("FAIL signed[%0d] cond_pass got %b exp %b", i, last_cp, e_cp);
            else passed++;
            checks++;
            if (observed() !== e_out) $display("FAIL signed[%0d] outputs got %h exp %h", i, observed(), e_out);
            else passed++;
        end
    endtask

    task automatic test_stall_flush();
        stim_t t[$];
        t.push_back(mk(1, COND_AL, 1, 1, 1, 1, 4'b0110, 0, 0, 0));
        for (int k = 0; k < 3; k++) t.push_back(mk(1, COND_AL, 1, 1, 1, 1, 4'hf, 1, 0, 0));
        for (int k = 0; k < 3; k++) t.push_back(mk(1, COND_AL, 1, 1, 1, 1, 4'hf, 1, 1, 0));
        t.push_back(mk(1, COND_AL, 1, 1, 1, 1, 4'hf, 0, 1, 0));
        foreach (t[i]) begin
            step(t[i]);
            e_cp = cp_q.pop_front(); e_out = exp_q.pop_front();
            checks++;
            if (last_cp !== e_cp[0]) $display("FAIL stall_flush[%0d] cond_pass got %b exp %b", i, last_cp, e_cp);
            else passed++;
            checks++;
            if (observed() !== e_out) $display("FAIL stall_flush[%0d] outputs got %h exp %h", i, observed(), e_out);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        stim_t t[$];
        t.push_back(mk(1, COND_AL, 1, 1, 0, 1, 4'b1010, 0, 0, 0));
        t.push_back(mk(1, COND_AL, 1, 1, 1, 1, 4'hf, 1, 1, 1));
        t.push_back(mk(0, COND_AL, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            e_cp = cp_q.pop_front(); e_out = exp_q.pop_front();
            checks++;
            if (last_cp !== e_cp[0]) $display("FAIL reset_mid[%0d] cond_pass got %b exp %b", i, last_cp, e_cp);
            else passed++;
            checks++;
            if (observed() !== e_out) $display("FAIL reset_mid[%0d] outputs got %h exp %h", i, observed(), e_out);
            else passed++;
        end
    endtask

    task automatic test_nv_al();
        stim_t t[$];
        t.push_back(mk(1, COND_AL, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
        t.push_back(mk(1, COND_NV, 1, 1, 1, 1, 4'hf, 0, 0, 0));
        t.push_back(mk(1, COND_AL, 0, 1, 0, 1, 4'h0, 0, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            e_cp = cp_q.pop_front(); e_out = exp_q.pop_front();
            checks++;
            if (last_cp !== e_cp[0]) $display("FAIL nv_al[%0d] cond_pass got %b exp %b", i, last_cp, e_cp);
            else passed++;
            checks++;
            if (observed() !== e_out) $display("FAIL nv_al[%0d] outputs got %h exp %h", i, observed(), e_out);
            else passed++;
        end
    endtask

    // random back-to-back flag producers/consumers with sporadic stall/flush/reset
    task automatic test_back_to_back();
        stim_t t;
        for (int i = 0; i < 200; i++) begin
            t = mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0);
            step(t);
            e_cp = cp_q.pop_front(); e_out = exp_q.pop_front();
            checks++;
            if (last_cp !== e_cp[0]) $display("FAIL b2b[%0d] cond_pass got %b exp %b", i, last_cp, e_cp);
            else passed++;
            checks++;
            if (observed() !== e_out) $display("FAIL b2b[%0d] outputs got %h exp %h", i, observed(), e_out);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
        cond_in = COND_AL; status_bits_in = 1'b0; alu_flags_in = '0;
        reg_write_enable_in = 1'b0; mem_write_enable_in = 1'b0;
        mem_to_reg_select_in = 1'b0; alu_result_in = '0; store_data_in = '0; rd_in = '0;
        last_cp = 1'b0;
        #1;
        test_reset();
        test_flag_eq();
        test_signed();
        test_stall_flush();
        test_reset_mid();
        test_nv_al();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
